spi_regfile: RTL and testbench
==============================

Name: spi_regfile

Overview:
- Register bank and sample buffer that sits directly downstream of the SPI slave (sspi) on the CPLD.
- Consumes the slave's address, write-data, rd and we strobes, and returns read data to the slave's din input.
- Holds capture control registers for the scope front end (run, trigger edge, trigger level, divider).
- Buffers captured sample bytes in a small FIFO that the host drains over SPI.

Parameters:
- ID_VAL, 8'h5A, value returned by ID register.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW (16).
- TRIG_RST, 8'h80, reset value of TRIG_LVL.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
- addr  in  7  register address from SPI slave.
- wdata  in  8  write data from SPI slave (its dout).
- we  in  1  write strobe, clk-synchronous.
- rd  in  1  read strobe, clk-synchronous.
- rdata  out  8  read data to SPI slave (its din).
- smp_data  in  8  captured sample byte.
- smp_valid  in  1  one-cycle sample qualifier.
- run  out  1  CTRL[0]; capture enable.
- trig_edge  out  1  CTRL[1]; 0 = rising, 1 = falling.
- trig_lvl  out  8  TRIG_LVL register.
- div  out  8  DIV register.
- irq  out  1  overflow | (count >= 2**(FIFO_AW-1)).

Behaviour:
- Reset (rst=1 on a clk edge):
  - run=0, trig_edge=0, trig_lvl=TRIG_RST, div=0, scratch=0.
  - FIFO pointers and count = 0; overflow=0; rdata=0; irq=0; rd edge-detect register=0.
- Register map (addr[6:0]); any other address reads 0x00 and ignores writes:
  - 0x00 ID, RO: ID_VAL.
  - 0x01 CTRL, RW: [0] run, [1] trig_edge, [2] flush (write-1 action, always reads 0), [7:3] read 0.
  - 0x02 TRIG_LVL, RW.
  - 0x03 DIV, RW.
  - 0x04 STATUS: [0] empty, [1] full, [2] overflow (W1C), [7:3] count[4:0], where count is 0..16.
  - 0x05 FIFO_DATA, RO: FIFO head byte; 0x00 when empty.
  - 0x06 SCRATCH, RW.
- Writes:
  - Every clk edge with we=1 applies wdata to addr; level-sensitive.
  - A held we repeats the write, which is idempotent.
  - Writes to RO registers are ignored.
- Read data:
  - rdata is registered. It equals the map value for the addr sampled on the previous edge, so latency is 1 clk.
  - rdata is updated every cycle regardless of rd.
- Pop:
  - Occurs on the rising edge of rd: rd=1 and previous rd=0, with addr==0x05 and FIFO not empty.
  - The byte on rdata when rd rises is the one consumed.
  - The head advances on that edge; rdata shows the new head one cycle later.
  - Holding rd high pops once. Pop when empty is ignored; no underflow flag.
- Push:
  - Occurs when run=1 and smp_valid=1. smp_data is written at the tail.
  - When run=0, samples are dropped silently and overflow is not set.
- Full:
  - The push/full decision uses the state before any same-cycle pop.
  - A push while full is dropped and sets overflow=1.
  - This holds even when a pop occurs in the same cycle; the pop still happens, so count becomes 15.
- Push and pop in the same cycle with 0 < count < 16: both happen and count is unchanged.
- Push when empty with a same-cycle pop: pop ignored, push happens, count becomes 1.
- Overflow flag:
  - Cleared only by writing 1 to STATUS[2], or by rst.
  - If a set and a clear occur in the same cycle, set wins.
- Flush (write CTRL with bit2=1):
  - Same cycle: pointers and count cleared; the same-cycle push is discarded.
  - overflow is unchanged.
  - run and trig_edge take the bits of the same write.
- Pointers wrap modulo depth. Full is count==2**FIFO_AW; empty is count==0.
- irq is registered and updates 1 cycle after its inputs.
- rst mid-transaction:
  - Aborts any pending pop; the FIFO contents are lost.
  - The rd edge detector clears, so an rd held high across reset release generates a pop on the first cycle after release.

Test Plan:
- Reset then read 0x00, 0x02, 0x04 → rdata 0x5A, 0x80, 0x01 (empty only); run=0, irq=0.
- Write CTRL=0x03, TRIG_LVL=0x3E, DIV=0xC7; read back → 0x03, 0x3E, 0xC7; run=1, trig_edge=1, trig_lvl=0x3E, div=0xC7.
- With run=1, push 0x11, 0x22, 0x33; STATUS reads 0x18 (count 3).
  - rd pulses at 0x05 (rd held 3 cycles each) → rdata 0x11, 0x22, 0x33 in order; then STATUS=0x01 and FIFO_DATA=0x00.
  - A fourth pulse is ignored.
- Push 17 samples 0x00..0x10 → STATUS=0x86 (count 16, full, overflow), irq=1.
  - Drain gives 0x00..0x0F.
  - Write STATUS=0x04 → overflow clears; irq=0 once count < 8.
- Fill to 16, then push and pop in the same cycle → popped byte is the oldest; new byte dropped; count=15; overflow=1.
- Fill 5 samples, write CTRL=0x05 with smp_valid=1 in the same cycle → count=0, overflow unchanged, run=1.
  - Assert rst with rd high → all regs at reset values; one pop attempt after release is ignored because the FIFO is empty.

Source files
------------

// File: rtl/spi_regfile.sv
// Register bank and sample FIFO downstream of the SPI slave: capture control
// registers for the scope front end plus a small byte buffer that the host drains.
module spi_regfile #(
  parameter logic [7:0]  ID_VAL   = 8'h5A,
  parameter int unsigned FIFO_AW  = 4,
  parameter logic [7:0]  TRIG_RST = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       we,
  input  logic       rd,
  output logic [7:0] rdata,
  input  logic [7:0] smp_data,
  input  logic       smp_valid,
  output logic       run,
  output logic       trig_edge,
  output logic [7:0] trig_lvl,
  output logic [7:0] div,
  output logic       irq
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  localparam logic [6:0] A_ID      = 7'h00;
  localparam logic [6:0] A_CTRL    = 7'h01;
  localparam logic [6:0] A_TRIG    = 7'h02;
  localparam logic [6:0] A_DIV     = 7'h03;
  localparam logic [6:0] A_STATUS  = 7'h04;
  localparam logic [6:0] A_FIFO    = 7'h05;
  localparam logic [6:0] A_SCRATCH = 7'h06;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CW-1:0]      count;
  logic               overflow;
  logic               rd_q;
  logic [7:0]         scratch;

  logic               empty_c;
  logic               full_c;
  logic               flush_c;
  logic               push_req_c;
  logic               push_do_c;
  logic               pop_do_c;
  logic               ovf_set_c;
  logic               ovf_clr_c;
  logic [7:0]         head_c;
  logic [7:0]         status_c;
  logic [7:0]         rd_mux_c;
  logic [CW-1:0]      count_next_c;

  // FIFO decisions are taken on the pre-edge state so a push while full is
  // always dropped, even if a pop frees a slot in the same cycle.
  always_comb begin
    empty_c    = (count == '0);
    full_c     = (count == CW'(DEPTH));
    flush_c    = we && (addr == A_CTRL) && wdata[2];
    push_req_c = run && smp_valid;
    push_do_c  = push_req_c && !full_c && !flush_c;
    pop_do_c   = rd && !rd_q && (addr == A_FIFO) && !empty_c && !flush_c;
    ovf_set_c  = push_req_c && full_c && !flush_c;
    ovf_clr_c  = we && (addr == A_STATUS) && wdata[2];
    head_c     = empty_c ? 8'h00 : mem[rd_ptr];
    status_c   = {5'(count), overflow, full_c, empty_c};

    count_next_c = count;
    if (flush_c) begin
      count_next_c = '0;
    end else begin
      unique case ({push_do_c, pop_do_c})
        2'b10:   count_next_c = count + CW'(1);
        2'b01:   count_next_c = count - CW'(1);
        default: count_next_c = count;
      endcase
    end
  end

  // Register map read mux
  always_comb begin
    rd_mux_c = 8'h00;
    unique case (addr)
      A_ID:      rd_mux_c = ID_VAL;
      A_CTRL:    rd_mux_c = {6'b0, trig_edge, run};
      A_TRIG:    rd_mux_c = trig_lvl;
      A_DIV:     rd_mux_c = div;
      A_STATUS:  rd_mux_c = status_c;
      A_FIFO:    rd_mux_c = head_c;
      A_SCRATCH: rd_mux_c = scratch;
      default:   rd_mux_c = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run       <= 1'b0;
      trig_edge <= 1'b0;
      trig_lvl  <= TRIG_RST;
      div       <= 8'h00;
      scratch   <= 8'h00;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      rdata     <= 8'h00;
      irq       <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      rdata <= rd_mux_c;
      irq   <= overflow || (count >= CW'(DEPTH / 2));
      rd_q  <= rd;

      if (we) begin
        unique case (addr)
          A_CTRL: begin
            run       <= wdata[0];
            trig_edge <= wdata[1];
          end
          A_TRIG:    trig_lvl <= wdata;
          A_DIV:     div      <= wdata;
          A_SCRATCH: scratch  <= wdata;
          default:   ;
        endcase
      end

      if (ovf_set_c) begin
        overflow <= 1'b1;
      end else if (ovf_clr_c) begin
        overflow <= 1'b0;
      end

      count <= count_next_c;
      if (flush_c) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_do_c) wr_ptr <= wr_ptr + FIFO_AW'(1);
        if (pop_do_c)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
    end
  end

  // Sample storage; contents are meaningless outside the valid window.
  always_ff @(posedge clk) begin
    if (push_do_c && !rst) begin
      mem[wr_ptr] <= smp_data;
    end
  end

endmodule

// File: tb/tb_spi_regfile.sv
// Self-checking bench for spi_regfile: directed scenarios followed by random
// traffic, all compared against a queue-based reference model every cycle.
module tb_spi_regfile;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       we = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] rdata;
  logic [7:0] smp_data = '0;
  logic       smp_valid = 1'b0;
  logic       run;
  logic       trig_edge;
  logic [7:0] trig_lvl;
  logic [7:0] div;
  logic       irq;

  int n_chk = 0;
  int n_err = 0;

  spi_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .rd        (rd),
    .rdata     (rdata),
    .smp_data  (smp_data),
    .smp_valid (smp_valid),
    .run       (run),
    .trig_edge (trig_edge),
    .trig_lvl  (trig_lvl),
    .div       (div),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] m_q[$];
  logic       m_run, m_edge, m_ovf, m_rd_prev;
  logic [7:0] m_trig, m_div, m_scr;
  logic [7:0] e_rdata;
  logic       e_irq;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] a);
    int n;
    n = m_q.size();
    case (a)
      7'h00:   return 8'h5A;
      7'h01:   return {6'b0, m_edge, m_run};
      7'h02:   return m_trig;
      7'h03:   return m_div;
      7'h04:   return {5'(n), m_ovf, n == 16, n == 0};
      7'h05:   return (n == 0) ? 8'h00 : m_q[0];
      7'h06:   return m_scr;
      default: return 8'h00;
    endcase
  endfunction

  // One clock: predict from current inputs, advance, then compare.
  task automatic tick();
    int  n;
    bit  pop, push, full, flush, oset, oclr;
    n = m_q.size();
    if (rst) begin
      m_q.delete();
      m_run = 0; m_edge = 0; m_ovf = 0; m_rd_prev = 0;
      m_trig = 8'h80; m_div = 8'h00; m_scr = 8'h00;
      e_rdata = 8'h00; e_irq = 1'b0;
    end else begin
      e_rdata = model_read(addr);
      e_irq   = m_ovf || (n >= 8);
      pop   = rd && !m_rd_prev && (addr == 7'h05) && (n > 0);
      push  = m_run && smp_valid;
      full  = (n == 16);
      flush = we && (addr == 7'h01) && wdata[2];
      oset  = push && full && !flush;
      oclr  = we && (addr == 7'h04) && wdata[2];
      if (flush) begin
        m_q.delete();
      end else begin
        if (pop) void'(m_q.pop_front());
        if (push && !full) m_q.push_back(smp_data);
      end
      if (we) begin
        case (addr)
          7'h01: begin m_run = wdata[0]; m_edge = wdata[1]; end
          7'h02: m_trig = wdata;
          7'h03: m_div = wdata;
          7'h06: m_scr = wdata;
          default: ;
        endcase
      end
      if (oset) m_ovf = 1'b1;
      else if (oclr) m_ovf = 1'b0;
      m_rd_prev = rd;
    end
    @(posedge clk);
    #1;
    check("rdata", rdata, e_rdata);
    check("irq", 8'(irq), 8'(e_irq));
    check("run", 8'(run), 8'(m_run));
    check("trig_edge", 8'(trig_edge), 8'(m_edge));
    check("trig_lvl", trig_lvl, m_trig);
    check("div", div, m_div);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [6:0] a, input logic [7:0] exp);
    addr = a;
    tick();
    check(tag, rdata, exp);
  endtask

  task automatic push(input logic [7:0] d);
    smp_data = d; smp_valid = 1'b1;
    tick();
    smp_valid = 1'b0;
  endtask

  // rd held three cycles at FIFO_DATA; checks the byte visible as rd rises
  task automatic pop_pulse(input string tag, input logic [7:0] exp);
    addr = 7'h05;
    tick();
    check(tag, rdata, exp);
    rd = 1'b1;
    repeat (3) tick();
    rd = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    rst = 1'b0;

    rd_check("id", 7'h00, 8'h5A);
    rd_check("trig_rst", 7'h02, 8'h80);
    rd_check("status_rst", 7'h04, 8'h01);
    check("run_rst", 8'(run), 8'h00);
    check("irq_rst", 8'(irq), 8'h00);

    wr(7'h01, 8'h03);
    wr(7'h02, 8'h3E);
    wr(7'h03, 8'hC7);
    wr(7'h06, 8'hA5);
    rd_check("ctrl_rb", 7'h01, 8'h03);
    rd_check("trig_rb", 7'h02, 8'h3E);
    rd_check("div_rb", 7'h03, 8'hC7);
    rd_check("scratch_rb", 7'h06, 8'hA5);
    wr(7'h7F, 8'hFF);
    rd_check("unmapped", 7'h7F, 8'h00);
    check("trig_edge_out", 8'(trig_edge), 8'h01);

    push(8'h11); push(8'h22); push(8'h33);
    rd_check("status_3", 7'h04, 8'h18);
    pop_pulse("pop0", 8'h11);
    pop_pulse("pop1", 8'h22);
    pop_pulse("pop2", 8'h33);
    rd_check("status_empty", 7'h04, 8'h01);
    rd_check("fifo_empty", 7'h05, 8'h00);
    pop_pulse("pop_empty", 8'h00);
    rd_check("status_still_empty", 7'h04, 8'h01);

    for (int i = 0; i < 17; i++) push(8'(i));
    rd_check("status_full_ovf", 7'h04, 8'h86);
    check("irq_full", 8'(irq), 8'h01);
    for (int i = 0; i < 16; i++) pop_pulse("drain", 8'(i));
    wr(7'h04, 8'h04);
    rd_check("status_ovf_clr", 7'h04, 8'h01);
    tick();
    check("irq_clr", 8'(irq), 8'h00);

    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    addr = 7'h05;
    tick();
    check("full_head", rdata, 8'hA0);
    rd = 1'b1; smp_valid = 1'b1; smp_data = 8'hEE;
    tick();
    rd = 1'b0; smp_valid = 1'b0;
    rd_check("status_15_ovf", 7'h04, 8'h7C);
    rd_check("head_after", 7'h05, 8'hA1);

    wr(7'h01, 8'h05);
    rd_check("flush_ovf_kept", 7'h04, 8'h05);
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    addr = 7'h01; wdata = 8'h05; we = 1'b1; smp_valid = 1'b1; smp_data = 8'h77;
    tick();
    we = 1'b0; smp_valid = 1'b0;
    rd_check("flush_push", 7'h04, 8'h05);
    check("run_after_flush", 8'(run), 8'h01);

    push(8'h99);
    addr = 7'h05; rd = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    rd = 1'b0;
    rd_check("status_post_rst", 7'h04, 8'h01);
    rd_check("scratch_post_rst", 7'h06, 8'h00);
    check("trig_post_rst", trig_lvl, 8'h80);
    check("div_post_rst", div, 8'h00);

    wr(7'h01, 8'h01);
    for (int c = 0; c < 3000; c++) begin
      addr      = ($urandom_range(0, 15) == 0) ? 7'h55 : 7'($urandom_range(0, 7));
      wdata     = 8'($urandom);
      we        = ($urandom_range(0, 3) == 0);
      if (we && addr == 7'h01 && $urandom_range(0, 3) != 0) wdata[2] = 1'b0;
      if (we && addr == 7'h01 && $urandom_range(0, 1) == 0) wdata[0] = 1'b1;
      rd        = ($urandom_range(0, 2) == 0);
      smp_valid = ($urandom_range(0, 1) == 0);
      smp_data  = 8'($urandom);
      rst       = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; we = 1'b0; rd = 1'b0; smp_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
